// File: rtl/sequential_divider_if.sv
// Request/response bundle for the sequential divider.
// The requester drives operands and start; the divider returns status and results.
interface sequential_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, sign_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Fixed-latency restoring divider, signed (DIV) or unsigned (DIVU).
// One quotient bit per CALC cycle, sign correction in SIGNFIX.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  sequential_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE, CALC, SIGNFIX, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic             dz, neg_a, neg_b;
  logic [WIDTH:0]   sh, trial;

  // A zero divisor keeps the raw dividend so the plain restoring
  // loop yields all-ones quotient and the untouched dividend.
  assign dz    = (bus.divisor == '0);
  assign neg_a = bus.sign_mode & bus.dividend[WIDTH-1] & ~dz;
  assign neg_b = bus.sign_mode & bus.divisor[WIDTH-1];

  assign sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial = sh - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = neg_a ? -bus.dividend : bus.dividend;
          dvs_d   = neg_b ? -bus.divisor : bus.divisor;
          qsign_d = neg_a ^ neg_b;
          rsign_d = neg_a;
          dbz_d   = dz;
        end
      end
      CALC: begin
        // The count reaches WIDTH one cycle after the last step.
        if (cnt_q == CW'(WIDTH)) begin
          state_d = SIGNFIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      SIGNFIX: begin
        state_d = DONE;
        quot_d  = qsign_q ? -quo_q : quo_q;
        remo_d  = rsign_q ? -rem_q : rem_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed scoreboard bench for sequential_divider.
// Driver queues expected results; a monitor checks each done pulse.
module tb_sequential_divider;
  localparam int W = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   n_done;
  exp_t sb[$];

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
        check("latency", W'(cyc), W'(e.cyc));
        @(negedge clk);
        check("done_pulse", W'(bus.done), '0);
        check("quot_hold", bus.quotient, e.q);
        check("dbz_hold", W'(bus.div_by_zero), W'(e.dbz));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  task automatic run(input logic sm, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eq,
                     input logic [W-1:0] er, input logic edz,
                     input bit repulse);
    wait_idle();
    bus.sign_mode = sm;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{q: eq, r: er, dbz: edz, cyc: cyc + LAT});
    @(negedge clk);
    bus.start     = 1'b0;
    bus.sign_mode = ~sm;
    bus.dividend  = 32'hDEAD_BEEF;
    bus.divisor   = 32'h0;
    if (repulse) begin
      repeat (5) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 32'd5;
      bus.divisor  = 32'd1;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    int t;
    n_cmp = 0;
    n_bad = 0;
    n_done = 0;
    bus.start = 1'b0;
    bus.sign_mode = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_quot", bus.quotient, '0);
    check("rst_rem", bus.remainder, '0);
    check("rst_dbz", W'(bus.div_by_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
    run(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0);
    run(1, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0);
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 0);
    run(0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 0, 1);
    run(0, 32'd0, 32'd5, 32'd0, 32'd0, 0, 0);
    run(1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 0, 0);
    run(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 0, 0);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0);
    run(0, 32'd7, 32'd100, 32'd0, 32'd7, 0, 0);
    run(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0);
    run(0, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 1, 0);
    run(1, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 0);

    wait_idle();
    bus.sign_mode = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd3;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    check("abort_quot", bus.quotient, '0);
    check("abort_rem", bus.remainder, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    run(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 0);

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("sb_drained", W'(sb.size()), '0);
    repeat (3) @(negedge clk);
    check("done_count", W'(n_done), W'(15));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
